// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer countdown controller: BCD MM:SS, run/pause/done sequencing.
// Optional DONE_BEEP_EN macro enables the post-completion beep hold in DONE.
module microwave_timer_ctrl #(
    parameter int BEEP_SECONDS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    output logic       div_rst,
    input  logic       load,
    input  logic [3:0] load_mt,
    input  logic [3:0] load_mu,
    input  logic [3:0] load_st,
    input  logic [3:0] load_su,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    output logic [3:0] mt,
    output logic [3:0] mu,
    output logic [3:0] st,
    output logic [3:0] su,
    output logic       running,
    output logic       heater_on,
    output logic       done,
    output logic       beep,
    output logic       load_err
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state;
    logic [3:0] nmt, nmu, nst, nsu;
    logic       dec_zero;
    logic       time_zero;
    logic       load_ok;

    // One-second decrement with the BCD borrow chain su -> st -> mu -> mt.
    always_comb begin
        nmt = mt;
        nmu = mu;
        nst = st;
        nsu = su - 4'd1;
        if (su == 4'd0) begin
            nsu = 4'd9;
            nst = st - 4'd1;
            if (st == 4'd0) begin
                nst = 4'd5;
                nmu = mu - 4'd1;
                if (mu == 4'd0) begin
                    nmu = 4'd9;
                    nmt = mt - 4'd1;
                end
            end
        end
    end

    assign dec_zero  = (nmt == 4'd0) && (nmu == 4'd0) &&
                       (nst == 4'd0) && (nsu == 4'd0);
    assign time_zero = (mt == 4'd0) && (mu == 4'd0) &&
                       (st == 4'd0) && (su == 4'd0);
    assign load_ok   = (load_mt <= 4'd9) && (load_mu <= 4'd9) &&
                       (load_st <= 4'd5) && (load_su <= 4'd9);

`ifdef DONE_BEEP_EN
    logic [3:0] beep_cnt;
`else
    assign beep = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            {mt, mu, st, su} <= '0;
            running   <= 1'b0;
            heater_on <= 1'b0;
            done      <= 1'b0;
            div_rst   <= 1'b0;
            load_err  <= 1'b0;
`ifdef DONE_BEEP_EN
            beep      <= 1'b0;
            beep_cnt  <= '0;
`endif
        end else begin
            done     <= 1'b0;
            div_rst  <= 1'b0;
            load_err <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                {mt, mu, st, su} <= '0;
                running   <= 1'b0;
                heater_on <= 1'b0;
`ifdef DONE_BEEP_EN
                beep      <= 1'b0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        if (load) begin
                            if (load_ok)
                                {mt, mu, st, su} <= {load_mt, load_mu, load_st, load_su};
                            else
                                load_err <= 1'b1;
                        end else if (start && !stop && door_closed && !time_zero) begin
                            state     <= RUN;
                            running   <= 1'b1;
                            heater_on <= 1'b1;
                            div_rst   <= 1'b1;
                        end
                    end
                    RUN: begin
                        // A pause wins over a coincident tick; that second is discarded.
                        if (!door_closed || stop) begin
                            state     <= PAUSE;
                            running   <= 1'b0;
                            heater_on <= 1'b0;
                        end else if (tick_1hz) begin
                            {mt, mu, st, su} <= {nmt, nmu, nst, nsu};
                            if (dec_zero) begin
                                state     <= DONE;
                                running   <= 1'b0;
                                heater_on <= 1'b0;
                                done      <= 1'b1;
`ifdef DONE_BEEP_EN
                                beep      <= 1'b1;
                                beep_cnt  <= 4'(BEEP_SECONDS);
`endif
                            end
                        end
                    end
                    PAUSE: begin
                        if (start && !stop && door_closed) begin
                            state     <= RUN;
                            running   <= 1'b1;
                            heater_on <= 1'b1;
                            div_rst   <= 1'b1;
                        end
                    end
                    DONE: begin
`ifdef DONE_BEEP_EN
                        if (!door_closed) begin
                            state <= IDLE;
                            beep  <= 1'b0;
                        end else if (tick_1hz) begin
                            if (beep_cnt <= 4'd1) begin
                                state    <= IDLE;
                                beep     <= 1'b0;
                                beep_cnt <= '0;
                            end else begin
                                beep_cnt <= beep_cnt - 4'd1;
                            end
                        end
`else
                        state <= IDLE;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
